univ_shift_reg: RTL and testbench

//   Parametrised successor to the single edge-triggered D flip-flop: a WIDTH-bit register bank

---
 rtl/univ_shift_reg.sv | 109 ++++++++++
 tb/tb_univ_shift_reg.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register with true/complement outputs and an
// auto-shift sequencer that repeats one shift/rotate op a programmed number of times.
module univ_shift_reg #(
    parameter int                 WIDTH     = 8,
    parameter int                 CNT_W     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               clear,
    input  logic [2:0]         mode,
    input  logic [WIDTH-1:0]   d,
    input  logic               sin_r,
    input  logic               sin_l,
    input  logic               start,
    input  logic [CNT_W-1:0]   amount,
    output logic [WIDTH-1:0]   q,
    output logic [WIDTH-1:0]   qbar,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_ROTR = 3'b100;
    localparam logic [2:0] OP_ROTL = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_INV  = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [2:0]       op_l;
    logic [CNT_W-1:0] count;
    logic             repeatable;

    // Next register value for a given operation; serial inputs are taken live.
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] v,
        input logic [WIDTH-1:0] load_val,
        input logic             sr,
        input logic             sl
    );
        logic [WIDTH-1:0] r;
        r = v;
        case (op)
            OP_HOLD: r = v;
            OP_LOAD: r = load_val;
            OP_SHR:  r = {sr, v[WIDTH-1:1]};
            OP_SHL:  r = {v[WIDTH-2:0], sl};
            OP_ROTR: r = {v[0], v[WIDTH-1:1]};
            OP_ROTL: r = {v[WIDTH-2:0], v[WIDTH-1]};
            OP_ASR:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            OP_INV:  r = ~v;
            default: r = v;
        endcase
        return r;
    endfunction

    // Only the shift/rotate family can be auto-repeated; hold, load and invert ignore start.
    assign repeatable = (mode >= OP_SHR) && (mode <= OP_ASR);

    always_ff @(posedge clk) begin
        if (clear) begin
            q     <= RESET_VAL;
            busy  <= 1'b0;
            done  <= 1'b0;
            count <= '0;
            op_l  <= OP_HOLD;
            state <= IDLE;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && repeatable) begin
                        if (amount != '0) begin
                            op_l  <= mode;
                            count <= amount;
                            busy  <= 1'b1;
                            state <= BUSY;
                        end else begin
                            done <= 1'b1;
                        end
                    end else begin
                        q <= apply_op(mode, q, d, sin_r, sin_l);
                    end
                end
                BUSY: begin
                    q     <= apply_op(op_l, q, d, sin_r, sin_l);
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign qbar = ~q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, CNT_W=4, RESET_VAL=0).
module tb_univ_shift_reg;

    logic       clk;
    logic       clear;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_r;
    logic       sin_l;
    logic       start;
    logic [3:0] amount;
    logic [7:0] q;
    logic [7:0] qbar;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cur;
    logic [7:0] exp_v;

    univ_shift_reg #(.WIDTH(8), .CNT_W(4), .RESET_VAL(8'h00)) dut (
        .clk(clk), .clear(clear), .mode(mode), .d(d), .sin_r(sin_r), .sin_l(sin_l),
        .start(start), .amount(amount), .q(q), .qbar(qbar), .busy(busy), .done(done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change after the falling edge; outputs are read at the falling edge.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [7:0] model_op(input logic [2:0] m, input logic [7:0] v,
                                            input logic [7:0] dv, input logic sr, input logic sl);
        case (m)
            3'd0: return v;
            3'd1: return dv;
            3'd2: return {sr, v[7:1]};
            3'd3: return {v[6:0], sl};
            3'd4: return {v[0], v[7:1]};
            3'd5: return {v[6:0], v[7]};
            3'd6: return {v[7], v[7:1]};
            default: return ~v;
        endcase
    endfunction

    task automatic load(input logic [7:0] v);
        mode = 3'b001; d = v; start = 1'b0;
        tick();
        checks++;
        if (q !== v) begin
            $display("FAIL load: q=%h expected %h", q, v); errors++;
        end
        mode = 3'b000;
        cur  = v;
    endtask

    task automatic test_reset;
        clear = 1'b1;
        tick();
        checks++;
        if (q !== 8'h00 || qbar !== 8'hFF || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_init: q=%h qbar=%h busy=%b done=%b expected 00 FF 0 0", q, qbar, busy, done);
            errors++;
        end
        clear = 1'b0;
        load(8'hA5);
        clear = 1'b1;
        tick();
        checks++;
        if (q !== 8'h00 || qbar !== 8'hFF || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_after_load: q=%h qbar=%h busy=%b done=%b expected 00 FF 0 0", q, qbar, busy, done);
            errors++;
        end
        clear = 1'b0;
    endtask

    task automatic test_load_hold;
        load(8'h3C);
        for (int i = 0; i < 3; i++) begin
            mode = 3'b000; d = 8'hFF;
            tick();
            checks++;
            if (q !== 8'h3C) begin
                $display("FAIL hold_%0d: q=%h expected 3c", i, q); errors++;
            end
        end
    endtask

    task automatic test_basic_ops;
        logic [2:0] m_tab[3];
        logic [7:0] e_tab[3];
        m_tab[0] = 3'b010; e_tab[0] = 8'h9E;
        m_tab[1] = 3'b011; e_tab[1] = 8'h3C;
        m_tab[2] = 3'b111; e_tab[2] = 8'hC3;
        sin_r = 1'b1; sin_l = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mode = m_tab[i];
            exp_q.push_back(e_tab[i]);
            tick();
            exp_v = exp_q.pop_front();
            checks++;
            if (q !== exp_v || qbar !== ~exp_v) begin
                $display("FAIL basic_op_%0d: q=%h qbar=%h expected %h", i, q, qbar, exp_v); errors++;
            end
        end
        mode = 3'b000;
        cur  = 8'hC3;
    endtask

    task automatic test_random_ops;
        for (int i = 0; i < 40; i++) begin
            mode  = 3'($urandom_range(0, 7));
            d     = 8'($urandom);
            sin_r = 1'($urandom);
            sin_l = 1'($urandom);
            start = 1'b0;
            cur   = model_op(mode, cur, d, sin_r, sin_l);
            exp_q.push_back(cur);
            tick();
            exp_v = exp_q.pop_front();
            checks++;
            if (q !== exp_v || qbar !== ~exp_v || busy !== 1'b0) begin
                $display("FAIL random_op_%0d: q=%h qbar=%h busy=%b expected %h", i, q, qbar, busy, exp_v); errors++;
            end
        end
        mode = 3'b000;
    endtask

    task automatic test_auto_shift;
        logic [7:0] seq[3];
        seq[0] = 8'h03; seq[1] = 8'h06; seq[2] = 8'h0C;
        load(8'h81);
        mode = 3'b101; start = 1'b1; amount = 4'd3;
        tick();
        checks++;
        if (q !== 8'h81 || busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL auto_e0: q=%h busy=%b done=%b expected 81 1 0", q, busy, done); errors++;
        end
        // Hostile inputs while busy: must all be ignored.
        mode = 3'b001; d = 8'hFF; start = 1'b0; amount = 4'd9;
        for (int i = 0; i < 3; i++) exp_q.push_back(seq[i]);
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            checks++;
            if (q !== exp_v || busy !== (i < 2) || done !== (i == 2)) begin
                $display("FAIL auto_e%0d: q=%h busy=%b done=%b expected %h %b %b", i + 1, q, busy, done,
                         exp_v, (i < 2), (i == 2));
                errors++;
            end
        end
        mode = 3'b000;
        tick();
        checks++;
        if (q !== 8'h0C || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL auto_after: q=%h busy=%b done=%b expected 0c 0 0", q, busy, done); errors++;
        end
        cur = 8'h0C;
    endtask

    task automatic test_clear_abort;
        load(8'h80);
        mode = 3'b110; start = 1'b1; amount = 4'd2;
        tick();
        start = 1'b0; mode = 3'b000;
        tick();
        checks++;
        if (q !== 8'hC0 || busy !== 1'b1) begin
            $display("FAIL abort_first_op: q=%h busy=%b expected c0 1", q, busy); errors++;
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL abort_clear: q=%h busy=%b done=%b expected 00 0 0", q, busy, done); errors++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h00) begin
                $display("FAIL abort_quiet_%0d: q=%h busy=%b done=%b expected 00 0 0", i, q, busy, done); errors++;
            end
        end
        cur = 8'h00;
    endtask

    task automatic test_zero_amount;
        load(8'h5A);
        mode = 3'b010; start = 1'b1; amount = 4'd0; sin_r = 1'b1;
        tick();
        checks++;
        if (q !== 8'h5A || done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL zero_amount: q=%h done=%b busy=%b expected 5a 1 0", q, done, busy); errors++;
        end
        start = 1'b0; mode = 3'b000;
        tick();
        checks++;
        if (q !== 8'h5A || done !== 1'b0) begin
            $display("FAIL zero_amount_after: q=%h done=%b expected 5a 0", q, done); errors++;
        end
        // Start on a non-repeatable mode is ignored and the op applies normally.
        mode = 3'b111; start = 1'b1; amount = 4'd5;
        tick();
        start = 1'b0; mode = 3'b000;
        checks++;
        if (q !== 8'hA5 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL start_on_invert: q=%h busy=%b done=%b expected a5 0 0", q, busy, done); errors++;
        end
        cur = 8'hA5;
    endtask

    task automatic test_back_to_back;
        int ops;
        load(8'h01);
        mode = 3'b100; start = 1'b1; amount = 4'd4;
        tick();
        start = 1'b0;
        ops = 0;
        for (int i = 0; i < 12 && busy === 1'b1; i++) begin
            start  = (i == 1);
            amount = 4'd15;
            tick();
            ops++;
        end
        start = 1'b0; mode = 3'b000;
        checks++;
        if (ops !== 4 || q !== 8'h10 || done !== 1'b1) begin
            $display("FAIL start_in_busy: ops=%0d q=%h done=%b expected 4 10 1", ops, q, done); errors++;
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== 8'h10) begin
            $display("FAIL start_in_busy_after: q=%h busy=%b done=%b expected 10 0 0", q, busy, done); errors++;
        end
        cur = 8'h10;
    endtask

    task automatic test_wrap;
        logic [2:0] m_tab[3];
        logic [7:0] s_tab[3];
        logic [3:0] a_tab[3];
        logic       l_tab[3];
        logic [7:0] e_tab[3];
        logic       got_done;
        m_tab[0] = 3'b101; s_tab[0] = 8'h01; a_tab[0] = 4'd9;  l_tab[0] = 1'b0; e_tab[0] = 8'h02;
        m_tab[1] = 3'b011; s_tab[1] = 8'hFF; a_tab[1] = 4'd10; l_tab[1] = 1'b0; e_tab[1] = 8'h00;
        m_tab[2] = 3'b100; s_tab[2] = 8'h01; a_tab[2] = 4'd15; l_tab[2] = 1'b0; e_tab[2] = 8'h02;
        for (int t = 0; t < 3; t++) begin
            load(s_tab[t]);
            mode = m_tab[t]; amount = a_tab[t]; start = 1'b1; sin_l = l_tab[t];
            tick();
            start = 1'b0; mode = 3'b000;
            got_done = 1'b0;
            for (int i = 0; i < 20 && !got_done; i++) begin
                tick();
                got_done = done;
            end
            checks++;
            if (!got_done || q !== e_tab[t]) begin
                $display("FAIL wrap_%0d: done_seen=%b q=%h expected 1 %h", t, got_done, q, e_tab[t]); errors++;
            end
        end
        cur = q;
    endtask

    task automatic test_random_auto;
        logic [2:0] m;
        logic [3:0] amt;
        for (int n = 0; n < 8; n++) begin
            load(8'($urandom));
            m = 3'($urandom_range(2, 6));
            amt = 4'($urandom_range(1, 12));
            mode = m; amount = amt; start = 1'b1;
            tick();
            start = 1'b0;
            checks++;
            if (q !== cur || busy !== 1'b1) begin
                $display("FAIL rauto_e0_%0d: q=%h busy=%b expected %h 1", n, q, busy, cur); errors++;
            end
            for (int k = 0; k < int'(amt); k++) begin
                mode  = 3'($urandom_range(0, 7));
                d     = 8'($urandom);
                sin_r = 1'($urandom);
                sin_l = 1'($urandom);
                cur   = model_op(m, cur, d, sin_r, sin_l);
                exp_q.push_back(cur);
                tick();
                exp_v = exp_q.pop_front();
                checks++;
                if (q !== exp_v || busy !== (k < int'(amt) - 1) || done !== (k == int'(amt) - 1)) begin
                    $display("FAIL rauto_%0d_%0d: q=%h busy=%b done=%b expected %h", n, k, q, busy, done, exp_v);
                    errors++;
                end
            end
            mode = 3'b000;
        end
    endtask

    initial begin
        clear = 1'b1; mode = 3'b000; d = 8'h00; sin_r = 1'b0; sin_l = 1'b0;
        start = 1'b0; amount = 4'd0;
        @(negedge clk);
        test_reset();
        test_load_hold();
        test_basic_ops();
        test_random_ops();
        test_auto_shift();
        test_clear_abort();
        test_zero_amount();
        test_back_to_back();
        test_wrap();
        test_random_auto();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
